// File: rtl/fifo_word_serializer.sv
// Drains 32-bit FIFO words and emits them MSB-first as bytes over a valid/ready stream.
// Optional FIFO_SER_PARITY_EN adds a registered even-parity bit (out_parity_o) per output byte.
module fifo_word_serializer #(
  parameter int unsigned WORD_W = 32,
  parameter int unsigned BYTE_W = 8,
  parameter int unsigned CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              fifo_empty_i,
  input  logic [WORD_W-1:0] fifo_data_i,
  output logic              fifo_en_o,
  output logic              fifo_rd_o,
  output logic [BYTE_W-1:0] out_data_o,
  output logic              out_valid_o,
  input  logic              out_ready_i,
`ifdef FIFO_SER_PARITY_EN
  output logic              out_parity_o,
`endif
  output logic              busy_o,
  output logic [CNT_W-1:0]  words_sent_o
);

  localparam int unsigned NB    = WORD_W / BYTE_W;
  localparam int unsigned IDX_W = (NB > 1) ? $clog2(NB) : 1;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_CAPT = 2'd2,
    ST_SEND = 2'd3
  } state_e;

  state_e             state_q, state_d;
  logic [WORD_W-1:0]  shreg_q, shreg_d;
  logic [IDX_W-1:0]   byte_idx_q, byte_idx_d;
  logic               fifo_rd_q, fifo_rd_d;
  logic               fifo_en_q;
  logic               out_valid_q, out_valid_d;
  logic [BYTE_W-1:0]  out_data_q, out_data_d;
  logic               busy_q, busy_d;
  logic [CNT_W-1:0]   words_sent_q, words_sent_d;
`ifdef FIFO_SER_PARITY_EN
  logic               parity_q;
`endif

  // Next-state and registered-output computation
  always_comb begin
    state_d      = state_q;
    shreg_d      = shreg_q;
    byte_idx_d   = byte_idx_q;
    fifo_rd_d    = 1'b0;
    out_valid_d  = out_valid_q;
    words_sent_d = words_sent_q;

    case (state_q)
      ST_IDLE: begin
        if (!fifo_empty_i) begin
          state_d   = ST_REQ;
          fifo_rd_d = 1'b1;
        end
      end
      ST_REQ: begin
        state_d = ST_CAPT;
      end
      ST_CAPT: begin
        shreg_d     = fifo_data_i;
        byte_idx_d  = '0;
        out_valid_d = 1'b1;
        state_d     = ST_SEND;
      end
      ST_SEND: begin
        if (out_valid_q && out_ready_i) begin
          shreg_d    = shreg_q << BYTE_W;
          byte_idx_d = byte_idx_q + IDX_W'(1);
          // Last byte: the empty flag sampled now decides whether to chain the next read
          if (byte_idx_q == IDX_W'(NB - 1)) begin
            words_sent_d = words_sent_q + CNT_W'(1);
            out_valid_d  = 1'b0;
            if (!fifo_empty_i) begin
              state_d   = ST_REQ;
              fifo_rd_d = 1'b1;
            end else begin
              state_d = ST_IDLE;
            end
          end
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    out_data_d = shreg_d[WORD_W-1 -: BYTE_W];
    busy_d     = (state_d != ST_IDLE);
  end

  // State and output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      shreg_q      <= '0;
      byte_idx_q   <= '0;
      fifo_rd_q    <= 1'b0;
      fifo_en_q    <= 1'b0;
      out_valid_q  <= 1'b0;
      out_data_q   <= '0;
      busy_q       <= 1'b0;
      words_sent_q <= '0;
`ifdef FIFO_SER_PARITY_EN
      parity_q     <= 1'b0;
`endif
    end else begin
      state_q      <= state_d;
      shreg_q      <= shreg_d;
      byte_idx_q   <= byte_idx_d;
      fifo_rd_q    <= fifo_rd_d;
      fifo_en_q    <= 1'b1;
      out_valid_q  <= out_valid_d;
      out_data_q   <= out_data_d;
      busy_q       <= busy_d;
      words_sent_q <= words_sent_d;
`ifdef FIFO_SER_PARITY_EN
      parity_q     <= ^out_data_d;
`endif
    end
  end

  assign fifo_en_o    = fifo_en_q;
  assign fifo_rd_o    = fifo_rd_q;
  assign out_data_o   = out_data_q;
  assign out_valid_o  = out_valid_q;
  assign busy_o       = busy_q;
  assign words_sent_o = words_sent_q;
`ifdef FIFO_SER_PARITY_EN
  assign out_parity_o = parity_q;
`endif

endmodule

// File: tb/tb_fifo_word_serializer.sv
// Directed bench for fifo_word_serializer: FIFO model, byte scoreboard, protocol monitor.
// A second instance with a 2-bit word counter exercises counter wrap.
module tb_fifo_word_serializer;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        fifo_empty = 1'b1;
  logic [31:0] fifo_data  = '0;
  logic        out_ready;

  logic        fifo_en, fifo_rd, out_valid, busy;
  logic [7:0]  out_data;
  logic [15:0] words_sent;
  logic        fifo_en_w, fifo_rd_w, out_valid_w, busy_w;
  logic [7:0]  out_data_w;
  logic [1:0]  words_sent_w;
`ifdef FIFO_SER_PARITY_EN
  logic        out_parity, out_parity_w;
`endif

  int checks = 0;
  int errors = 0;

  logic [31:0] fifo_mem[$];
  logic [7:0]  exp_q[$];
  int          rd_cnt = 0;
  int          rd_viol = 0;
  int          rd_consec = 0;
  logic        prev_rd = 1'b0;

  always #5 clk = ~clk;

  fifo_word_serializer #(.WORD_W(32), .BYTE_W(8), .CNT_W(16)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .fifo_empty_i (fifo_empty),
    .fifo_data_i  (fifo_data),
    .fifo_en_o    (fifo_en),
    .fifo_rd_o    (fifo_rd),
    .out_data_o   (out_data),
    .out_valid_o  (out_valid),
    .out_ready_i  (out_ready),
`ifdef FIFO_SER_PARITY_EN
    .out_parity_o (out_parity),
`endif
    .busy_o       (busy),
    .words_sent_o (words_sent)
  );

  fifo_word_serializer #(.WORD_W(32), .BYTE_W(8), .CNT_W(2)) dut_w (
    .clk          (clk),
    .rst_n        (rst_n),
    .fifo_empty_i (fifo_empty),
    .fifo_data_i  (fifo_data),
    .fifo_en_o    (fifo_en_w),
    .fifo_rd_o    (fifo_rd_w),
    .out_data_o   (out_data_w),
    .out_valid_o  (out_valid_w),
    .out_ready_i  (out_ready),
`ifdef FIFO_SER_PARITY_EN
    .out_parity_o (out_parity_w),
`endif
    .busy_o       (busy_w),
    .words_sent_o (words_sent_w)
  );

  // FIFO model with registered empty flag, plus read-strobe protocol monitor
  always @(posedge clk) begin
    if (fifo_rd) begin
      rd_cnt <= rd_cnt + 1;
      if (fifo_empty) rd_viol <= rd_viol + 1;
      if (prev_rd)    rd_consec <= rd_consec + 1;
      if (fifo_mem.size() > 0) fifo_data <= fifo_mem.pop_front();
    end
    prev_rd    <= fifo_rd;
    fifo_empty <= (fifo_mem.size() == 0);
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic push_word(input logic [31:0] w);
    fifo_mem.push_back(w);
    for (int b = 3; b >= 0; b--) exp_q.push_back(8'(w >> (8 * b)));
  endtask

  // Consume n bytes; optionally hold ready low for stall_len cycles on byte stall_at
  task automatic collect(input int n, input int stall_at, input int stall_len,
                         output int first_c, output int last_c);
    int got;
    int stall_left;
    int c;
    logic [7:0] exp_b;
    got = 0; stall_left = stall_len; c = 0;
    first_c = -1; last_c = -1;
    while (got < n && c < 400) begin
      @(negedge clk);
      c++;
      if (out_valid) begin
        if (got == stall_at && stall_left > 0) begin
          out_ready = 1'b0;
          stall_left--;
          exp_b = (exp_q.size() > 0) ? exp_q[0] : 8'hxx;
          chk("hold_data", 32'(out_data), 32'(exp_b));
        end else begin
          out_ready = 1'b1;
          exp_b = (exp_q.size() > 0) ? exp_q.pop_front() : 8'hxx;
          chk("byte", 32'(out_data), 32'(exp_b));
`ifdef FIFO_SER_PARITY_EN
          chk("parity", 32'(out_parity), 32'(^exp_b));
`endif
          if (first_c < 0) first_c = c;
          last_c = c;
          got++;
        end
      end
    end
    out_ready = 1'b1;
    chk("bytes_received", 32'(got), 32'(n));
  endtask

  initial begin
    int f, l;
    rst_n     = 1'b0;
    out_ready = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_fifo_en",    32'(fifo_en),    32'd0);
    chk("rst_fifo_rd",    32'(fifo_rd),    32'd0);
    chk("rst_out_valid",  32'(out_valid),  32'd0);
    chk("rst_out_data",   32'(out_data),   32'd0);
    chk("rst_busy",       32'(busy),       32'd0);
    chk("rst_words_sent", 32'(words_sent), 32'd0);
`ifdef FIFO_SER_PARITY_EN
    chk("rst_parity",     32'(out_parity), 32'd0);
`endif
    rst_n = 1'b1;
    @(negedge clk);
    chk("fifo_en_after_rst", 32'(fifo_en), 32'd1);
    chk("idle_busy",         32'(busy),    32'd0);

    // Asynchronous reset in the middle of a word
    push_word(32'hDEADBEEF);
    collect(1, -1, 0, f, l);
    @(negedge clk);
    chk("mid_send_byte1", 32'(out_data), 32'hAD);
    chk("mid_send_valid", 32'(out_valid), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("async_out_valid",  32'(out_valid),  32'd0);
    chk("async_out_data",   32'(out_data),   32'd0);
    chk("async_busy",       32'(busy),       32'd0);
    chk("async_fifo_en",    32'(fifo_en),    32'd0);
    chk("async_fifo_rd",    32'(fifo_rd),    32'd0);
    chk("async_words_sent", 32'(words_sent), 32'd0);
    exp_q.delete();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (5) @(negedge clk);
    chk("post_rst_busy",   32'(busy),      32'd0);
    chk("post_rst_valid",  32'(out_valid), 32'd0);
    chk("post_rst_rd_cnt", 32'(rd_cnt),    32'd1);

    // Single word, full-rate sink
    push_word(32'h11223344);
    collect(4, -1, 0, f, l);
    chk("single_latency", 32'(f),     32'd4);
    chk("single_span",    32'(l - f), 32'd3);
    @(negedge clk);
    chk("single_words",  32'(words_sent), 32'd1);
    chk("single_busy",   32'(busy),       32'd0);
    chk("single_valid",  32'(out_valid),  32'd0);
    chk("single_rd_cnt", 32'(rd_cnt),     32'd2);

    // Backpressure on the second byte
    push_word(32'hA5A55A5A);
    collect(4, 1, 5, f, l);
    chk("bp_span", 32'(l - f), 32'd8);
    @(negedge clk);
    chk("bp_words", 32'(words_sent), 32'd2);

    // Eight words back to back
    for (int i = 0; i < 8; i++) push_word($urandom);
    collect(32, -1, 0, f, l);
    chk("b2b_span", 32'(l - f), 32'd45);
    @(negedge clk);
    chk("b2b_words",     32'(words_sent),   32'd10);
    chk("b2b_rd_cnt",    32'(rd_cnt),       32'd11);
    chk("b2b_busy",      32'(busy),         32'd0);
    chk("narrow_cnt_10", 32'(words_sent_w), 32'd2);

    // Counter wrap on the narrow instance; first word also has alternating byte parity
    push_word(32'h01030700);
    collect(4, -1, 0, f, l);
    @(negedge clk);
    chk("narrow_cnt_max", 32'(words_sent_w), 32'd3);
    push_word(32'hFFFF0001);
    collect(4, -1, 0, f, l);
    @(negedge clk);
    chk("narrow_cnt_wrap", 32'(words_sent_w), 32'd0);
    chk("wide_words",      32'(words_sent),   32'd12);

    chk("rd_while_empty",  32'(rd_viol),       32'd0);
    chk("rd_consecutive",  32'(rd_consec),     32'd0);
    chk("scoreboard_left", 32'(exp_q.size()),  32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
